// File: rtl/trax_turn_sequencer.sv
// Turn-level controller for the Trax player.
// Runs the board engines one at a time through a full turn using start/done handshakes:
//   apply -> auto-complete (repeated) -> commit -> optional shift-down/shift-right
//   -> choose (only after an opponent move) -> apply our move -> ... -> hand our move to tx.
// Ports:
//   clk, reset (async active-low), my_color (0=white moves first, sampled after reset release)
//   rx_valid/rx_move         opponent move from the transceiver
//   tx_ready/tx_start/tx_move our move to the transceiver
//   upd_*, ac_*, cmt_*, shd_*, shr_*, ch_*  engine start pulses and done/result inputs
//   busy                     high in every state except IDLE and ERR
//   err                      sticky: engine timeout or move received while busy
module trax_turn_sequencer #(
  parameter int unsigned MOVE_W        = 22,
  parameter int unsigned MAX_AC_PASSES = 8,
  parameter int unsigned TIMEOUT_CYC   = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              my_color,
  input  logic              rx_valid,
  input  logic [MOVE_W-1:0] rx_move,
  input  logic              tx_ready,
  output logic              tx_start,
  output logic [MOVE_W-1:0] tx_move,
  output logic              upd_start,
  output logic [MOVE_W-1:0] upd_move,
  input  logic              upd_done,
  output logic              ac_start,
  input  logic              ac_done,
  input  logic              ac_changed,
  output logic              cmt_start,
  input  logic              cmt_done,
  input  logic [1:0]        cmt_shift,
  output logic              shd_start,
  input  logic              shd_done,
  output logic              shr_start,
  input  logic              shr_done,
  output logic              ch_start,
  input  logic              ch_done,
  input  logic [MOVE_W-1:0] ch_move,
  output logic              busy,
  output logic              err
);

  localparam int unsigned PW = $clog2(MAX_AC_PASSES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  // White's opening move: type 1 placed at (0,0).
  localparam logic [MOVE_W-1:0] FIRST_MOVE = {2'b01, {(MOVE_W - 2){1'b0}}};

  typedef enum logic [3:0] {
    StIdle, StApply, StAutoc, StCommit, StShdn, StShrt, StChoose, StTxwait, StErr
  } state_e;

  state_e        state;
  logic          side;        // 0: applying opponent move, 1: applying our move
  logic          first_turn;
  logic          fresh;       // high only in the first cycle after reset release
  logic          shr_pend;    // shift-right still owed after a shift-down
  logic [PW-1:0] passes;
  logic [TW-1:0] cnt;

  logic eng_done;
  logic start_now;
  logic acc;
  logic tmo;
  logic more_ac;

  always_comb begin
    eng_done = 1'b0;
    case (state)
      StApply:  eng_done = upd_done;
      StAutoc:  eng_done = ac_done;
      StCommit: eng_done = cmt_done;
      StShdn:   eng_done = shd_done;
      StShrt:   eng_done = shr_done;
      StChoose: eng_done = ch_done;
      default:  eng_done = 1'b0;
    endcase
    // A done landing in the same cycle as its start pulse is stale and ignored.
    start_now = upd_start | ac_start | cmt_start | shd_start | shr_start | ch_start;
    acc       = eng_done & ~start_now;
    tmo       = (cnt == TW'(TIMEOUT_CYC - 1));
    more_ac   = ac_changed && ((32'(passes) + 32'd1) < MAX_AC_PASSES);
  end

  assign busy = (state != StIdle) && (state != StErr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= StIdle;
      side       <= 1'b0;
      first_turn <= 1'b1;
      fresh      <= 1'b1;
      shr_pend   <= 1'b0;
      passes     <= '0;
      cnt        <= '0;
      upd_start  <= 1'b0;
      ac_start   <= 1'b0;
      cmt_start  <= 1'b0;
      shd_start  <= 1'b0;
      shr_start  <= 1'b0;
      ch_start   <= 1'b0;
      tx_start   <= 1'b0;
      tx_move    <= '0;
      upd_move   <= '0;
      err        <= 1'b0;
    end else begin
      upd_start <= 1'b0;
      ac_start  <= 1'b0;
      cmt_start <= 1'b0;
      shd_start <= 1'b0;
      shr_start <= 1'b0;
      ch_start  <= 1'b0;
      tx_start  <= 1'b0;
      fresh     <= 1'b0;
      // Engine wait states: count toward timeout unless a transition below clears it.
      if (busy) cnt <= cnt + 1'b1;
      if (rx_valid && busy) err <= 1'b1;

      case (state)
        StIdle: begin
          if (first_turn && fresh && !my_color) begin
            upd_move   <= FIRST_MOVE;
            tx_move    <= FIRST_MOVE;
            side       <= 1'b1;
            first_turn <= 1'b0;
            upd_start  <= 1'b1;
            cnt        <= '0;
            state      <= StApply;
            if (rx_valid) err <= 1'b1;  // opening move wins, opponent move dropped
          end else if (rx_valid) begin
            upd_move   <= rx_move;
            side       <= 1'b0;
            first_turn <= 1'b0;
            upd_start  <= 1'b1;
            cnt        <= '0;
            state      <= StApply;
          end
        end
        StApply: begin
          if (acc) begin
            passes   <= '0;
            ac_start <= 1'b1;
            cnt      <= '0;
            state    <= StAutoc;
          end else if (tmo) begin
            err   <= 1'b1;
            state <= StErr;
          end
        end
        StAutoc: begin
          if (acc) begin
            cnt <= '0;
            if (passes != PW'(MAX_AC_PASSES)) passes <= passes + 1'b1;
            if (more_ac) begin
              ac_start <= 1'b1;
            end else begin
              cmt_start <= 1'b1;
              state     <= StCommit;
            end
          end else if (tmo) begin
            err   <= 1'b1;
            state <= StErr;
          end
        end
        StCommit: begin
          if (acc) begin
            cnt      <= '0;
            shr_pend <= cmt_shift[0];
            if (cmt_shift[1]) begin
              shd_start <= 1'b1;
              state     <= StShdn;
            end else if (cmt_shift[0]) begin
              shr_start <= 1'b1;
              state     <= StShrt;
            end else if (side) begin
              state <= StTxwait;
            end else begin
              ch_start <= 1'b1;
              state    <= StChoose;
            end
          end else if (tmo) begin
            err   <= 1'b1;
            state <= StErr;
          end
        end
        StShdn: begin
          if (acc) begin
            cnt <= '0;
            if (shr_pend) begin
              shr_start <= 1'b1;
              state     <= StShrt;
            end else if (side) begin
              state <= StTxwait;
            end else begin
              ch_start <= 1'b1;
              state    <= StChoose;
            end
          end else if (tmo) begin
            err   <= 1'b1;
            state <= StErr;
          end
        end
        StShrt: begin
          if (acc) begin
            cnt <= '0;
            if (side) begin
              state <= StTxwait;
            end else begin
              ch_start <= 1'b1;
              state    <= StChoose;
            end
          end else if (tmo) begin
            err   <= 1'b1;
            state <= StErr;
          end
        end
        StChoose: begin
          if (acc) begin
            upd_move  <= ch_move;
            tx_move   <= ch_move;
            side      <= 1'b1;
            upd_start <= 1'b1;
            cnt       <= '0;
            state     <= StApply;
          end else if (tmo) begin
            err   <= 1'b1;
            state <= StErr;
          end
        end
        StTxwait: begin
          cnt <= '0;  // waiting on the transceiver, not an engine
          if (tx_ready) begin
            tx_start <= 1'b1;
            state    <= StIdle;
          end
        end
        StErr: begin
          cnt <= '0;
        end
        default: begin
          err   <= 1'b1;
          state <= StErr;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trax_turn_sequencer.sv
module tb_trax_turn_sequencer;
  localparam int MW = 22;
  localparam int AC_MAX = 8;
  localparam logic [MW-1:0] FIRST = 22'h100000;

  // Event kinds seen on the start outputs.
  localparam int EV_UPD = 1, EV_AC = 2, EV_CMT = 3, EV_SHD = 4, EV_SHR = 5, EV_CH = 6, EV_TX = 7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic my_color = 1'b0;
  logic rx_valid = 1'b0;
  logic [MW-1:0] rx_move = '0;
  logic tx_ready = 1'b1;
  logic tx_start, upd_start, ac_start, cmt_start, shd_start, shr_start, ch_start, busy, err;
  logic [MW-1:0] tx_move, upd_move;
  logic upd_done = 0, ac_done = 0, ac_changed = 0, cmt_done = 0, shd_done = 0, shr_done = 0;
  logic ch_done = 0;
  logic [1:0] cmt_shift = '0;
  logic [MW-1:0] ch_move = '0;

  always #5 clk = ~clk;

  trax_turn_sequencer dut (
    .clk(clk), .reset(reset), .my_color(my_color),
    .rx_valid(rx_valid), .rx_move(rx_move),
    .tx_ready(tx_ready), .tx_start(tx_start), .tx_move(tx_move),
    .upd_start(upd_start), .upd_move(upd_move), .upd_done(upd_done),
    .ac_start(ac_start), .ac_done(ac_done), .ac_changed(ac_changed),
    .cmt_start(cmt_start), .cmt_done(cmt_done), .cmt_shift(cmt_shift),
    .shd_start(shd_start), .shd_done(shd_done),
    .shr_start(shr_start), .shr_done(shr_done),
    .ch_start(ch_start), .ch_done(ch_done), .ch_move(ch_move),
    .busy(busy), .err(err)
  );

  typedef struct {
    int          kind;
    logic [MW-1:0] move;
    bit          chk;
  } ev_t;

  typedef struct {
    bit            color;
    logic [MW-1:0] rx_mv;
    logic [MW-1:0] ch_mv;
    bit            chg;
    logic [1:0]    shift;
    logic [MW-1:0] exp_tx;
  } vec_t;

  ev_t sb_q[$];
  int total = 0;
  int bad = 0;
  bit mon_en = 0;
  bit tx_seen = 0;
  bit ch_never = 0;
  bit ac_chg_cfg = 0;
  logic [1:0] shift_cfg = '0;
  logic [MW-1:0] ch_cfg = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int start_kind();
    if (upd_start) return EV_UPD;
    if (ac_start)  return EV_AC;
    if (cmt_start) return EV_CMT;
    if (shd_start) return EV_SHD;
    if (shr_start) return EV_SHR;
    if (ch_start)  return EV_CH;
    if (tx_start)  return EV_TX;
    return 0;
  endfunction

  task automatic push_ev(input int kind, input logic [MW-1:0] mv, input bit chk);
    ev_t e;
    e.kind = kind;
    e.move = mv;
    e.chk  = chk;
    sb_q.push_back(e);
  endtask

  // Expected start sequence for one apply pass of the turn.
  task automatic push_pass(input logic [MW-1:0] mv, input bit chg, input logic [1:0] sh,
                           input bit side);
    push_ev(EV_UPD, mv, 1'b1);
    for (int i = 0; i < (chg ? AC_MAX : 1); i++) push_ev(EV_AC, '0, 1'b0);
    push_ev(EV_CMT, '0, 1'b0);
    if (sh[1]) push_ev(EV_SHD, '0, 1'b0);
    if (sh[0]) push_ev(EV_SHR, '0, 1'b0);
    if (side) push_ev(EV_TX, mv, 1'b1);
    else push_ev(EV_CH, '0, 1'b0);
  endtask

  // Engine model (done 2 cycles after start) plus scoreboard of start events.
  initial begin
    int cd;
    int pk;
    int k;
    ev_t e;
    cd = 0;
    pk = 0;
    forever begin
      @(negedge clk);
      upd_done = 0; ac_done = 0; ac_changed = 0; cmt_done = 0; cmt_shift = '0;
      shd_done = 0; shr_done = 0; ch_done = 0; ch_move = '0;
      if (!reset) begin
        cd = 0;
        pk = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            case (pk)
              EV_UPD: upd_done = 1;
              EV_AC:  begin ac_done = 1; ac_changed = ac_chg_cfg; end
              EV_CMT: begin cmt_done = 1; cmt_shift = shift_cfg; end
              EV_SHD: shd_done = 1;
              EV_SHR: shr_done = 1;
              EV_CH:  begin ch_done = 1; ch_move = ch_cfg; end
              default: ;
            endcase
          end
        end
        k = start_kind();
        if (k == EV_TX) tx_seen = 1;
        if (k != 0 && k != EV_TX && !(k == EV_CH && ch_never)) begin
          pk = k;
          cd = 2;
        end
        if (mon_en && k != 0) begin
          if (sb_q.size() == 0) begin
            check("extra start", k, 0);
          end else begin
            e = sb_q.pop_front();
            check("event order", k, e.kind);
            if (e.chk && k == EV_TX) check("tx_move at tx_start", tx_move, e.move);
            if (e.chk && k == EV_UPD) check("upd_move at upd_start", upd_move, e.move);
          end
        end
      end
    end
  end

  task automatic do_reset(input bit color);
    mon_en = 0;
    @(negedge clk);
    reset = 0;
    my_color = color;
    rx_valid = 0;
    tx_seen = 0;
    ch_never = 0;
    sb_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_tx(input int maxc, output bit ok);
    ok = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (tx_seen) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    bit ok;
    vecs[0] = '{1'b0, 22'h000000, 22'h000000, 1'b0, 2'b00, 22'h100000};
    vecs[1] = '{1'b1, 22'h200000, 22'h300401, 1'b0, 2'b00, 22'h300401};
    vecs[2] = '{1'b1, 22'h200000, 22'h300401, 1'b0, 2'b11, 22'h300401};
    vecs[3] = '{1'b0, 22'h000000, 22'h000000, 1'b1, 2'b00, 22'h100000};
    vecs[4] = '{1'b1, 22'h012345, 22'h1abcde, 1'b0, 2'b01, 22'h1abcde};
    vecs[5] = '{1'b0, 22'h000000, 22'h000000, 1'b0, 2'b10, 22'h100000};

    // Asynchronous reset values.
    #3 reset = 0;
    #1;
    check("reset busy", busy, 0);
    check("reset err", err, 0);
    check("reset starts", {tx_start, upd_start, ac_start, cmt_start, shd_start, shr_start,
                           ch_start}, 0);
    check("reset tx_move", tx_move, 0);
    check("reset upd_move", upd_move, 0);

    foreach (vecs[i]) begin
      do_reset(vecs[i].color);
      ac_chg_cfg = vecs[i].chg;
      shift_cfg  = vecs[i].shift;
      ch_cfg     = vecs[i].ch_mv;
      if (!vecs[i].color) begin
        push_pass(FIRST, vecs[i].chg, vecs[i].shift, 1'b1);
      end else begin
        push_pass(vecs[i].rx_mv, vecs[i].chg, vecs[i].shift, 1'b0);
        push_pass(vecs[i].ch_mv, vecs[i].chg, vecs[i].shift, 1'b1);
      end
      mon_en = 1;
      reset = 1;
      if (vecs[i].color) begin
        repeat (3) @(negedge clk);
        check("black idle before rx", busy, 0);
        rx_valid = 1;
        rx_move = vecs[i].rx_mv;
        @(negedge clk);
        rx_valid = 0;
      end
      wait_tx(3000, ok);
      check("tx_start seen", ok, 1);
      check("tx_move", tx_move, vecs[i].exp_tx);
      check("no err", err, 0);
      @(negedge clk);
      check("idle after tx", busy, 0);
      check("events left", sb_q.size(), 0);
    end

    // Chooser never answers: timeout to ERR, then nothing else starts.
    do_reset(1'b1);
    ch_never = 1;
    ac_chg_cfg = 0;
    shift_cfg = '0;
    push_pass(22'h200000, 1'b0, 2'b00, 1'b0);
    mon_en = 1;
    reset = 1;
    repeat (2) @(negedge clk);
    rx_valid = 1;
    rx_move = 22'h200000;
    @(negedge clk);
    rx_valid = 0;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (sb_q.size() == 0) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check("reached choose", ok, 1);
    repeat (4000) @(negedge clk);
    check("no early timeout", err, 0);
    check("busy while choosing", busy, 1);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (err) begin
        ok = 1;
        break;
      end
    end
    check("timeout err", ok, 1);
    check("err state not busy", busy, 0);
    repeat (50) @(negedge clk);
    check("err sticky", err, 1);

    // Reset asserted mid-AUTOC takes effect without a clock edge.
    do_reset(1'b0);
    ac_chg_cfg = 1;
    push_pass(FIRST, 1'b1, 2'b00, 1'b1);
    mon_en = 1;
    reset = 1;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ac_start) begin
        ok = 1;
        break;
      end
    end
    check("ac_start seen", ok, 1);
    @(negedge clk);
    check("busy in autoc", busy, 1);
    @(posedge clk);
    #2 reset = 0;
    #1;
    check("async rst busy", busy, 0);
    check("async rst tx_move", tx_move, 0);
    check("async rst upd_move", upd_move, 0);
    check("async rst ac_start", ac_start, 0);
    mon_en = 0;

    // Opponent move while busy: dropped, err set, turn still completes.
    do_reset(1'b0);
    ac_chg_cfg = 0;
    push_pass(FIRST, 1'b0, 2'b00, 1'b1);
    mon_en = 1;
    reset = 1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (upd_start) begin
        ok = 1;
        break;
      end
    end
    check("upd_start seen", ok, 1);
    rx_valid = 1;
    rx_move = 22'h2aaaaa;
    @(negedge clk);
    rx_valid = 0;
    check("rx while busy err", err, 1);
    check("rx while busy continues", busy, 1);
    wait_tx(500, ok);
    check("tx after busy rx", ok, 1);
    check("tx_move after busy rx", tx_move, FIRST);
    check("events left busy rx", sb_q.size(), 0);

    // Opponent move on the same cycle as white's opening: opening wins, err set.
    do_reset(1'b0);
    rx_valid = 1;
    rx_move = 22'h2aaaaa;
    push_pass(FIRST, 1'b0, 2'b00, 1'b1);
    mon_en = 1;
    reset = 1;
    @(negedge clk);
    rx_valid = 0;
    check("collision err", err, 1);
    wait_tx(500, ok);
    check("tx after collision", ok, 1);
    check("tx_move after collision", tx_move, FIRST);
    check("events left collision", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
